// File: rtl/sprite_attr_table.sv
// Sprite attribute store: the host edits a shadow bank over Avalon-MM, and a commit copies it
// into the active bank during vertical blank. The display stage reads the active bank.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no copy in progress; waits for vblank_start with pending set
// ST_COPY | copies shadow[cnt] -> active[cnt], one sprite per clk
module sprite_attr_table #(
  parameter int N_SPRITES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [5:0]       address,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  input  logic             vblank_start,
  input  logic [IDX_W-1:0] disp_idx,
  output logic [7:0]       disp_x,
  output logic [7:0]       disp_y,
  output logic [7:0]       disp_pat,
  output logic [7:0]       disp_flags,
  output logic             commit_done
);

  typedef enum logic {ST_IDLE, ST_COPY} state_t;

  localparam logic [3:0]       N_LIM = 4'(N_SPRITES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_SPRITES - 1);

  // Each sprite entry is packed as {flags, pattern, y, x}.
  logic [31:0] shadow [N_SPRITES];
  logic [31:0] active [N_SPRITES];

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             pending;
  logic [7:0]       frame_cnt;

  logic             wr_acc;
  logic             rd_req;
  logic             sprite_sel;
  logic             slot_ok;
  logic [2:0]       slot_full;
  logic [IDX_W-1:0] slot;
  logic [1:0]       fld;
  logic             copying;
  logic [7:0]       rd_mux;

  always_comb begin
    copying     = (state == ST_COPY);
    waitrequest = copying && chipselect && write;
    wr_acc      = chipselect && write && !waitrequest;
    rd_req      = chipselect && read;
    sprite_sel  = !address[5];
    slot_full   = address[4:2];
    slot_ok     = ({1'b0, slot_full} < N_LIM);
    slot        = slot_full[IDX_W-1:0];
    fld         = address[1:0];
  end

  always_comb begin
    rd_mux = 8'h00;
    if (sprite_sel) begin
      if (slot_ok) rd_mux = shadow[slot][{fld, 3'b000} +: 8];
    end else begin
      case (address[4:0])
        5'h00:   rd_mux = {7'b0, pending};
        5'h01:   rd_mux = {6'b0, copying, pending};
        5'h02:   rd_mux = frame_cnt;
        default: rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      frame_cnt   <= 8'h00;
      commit_done <= 1'b0;
      readdata    <= 8'h00;
      disp_x      <= 8'h00;
      disp_y      <= 8'h00;
      disp_pat    <= 8'h00;
      disp_flags  <= 8'h00;
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (vblank_start && pending) begin
            state <= ST_COPY;
            cnt   <= '0;
          end
        end
        ST_COPY: begin
          active[cnt] <= shadow[cnt];
          cnt         <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            frame_cnt   <= frame_cnt + 8'd1;
            commit_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Writes are stalled throughout COPY, so this never races the pending clear above.
      if (wr_acc) begin
        if (sprite_sel) begin
          if (slot_ok) shadow[slot][{fld, 3'b000} +: 8] <= writedata;
        end else if (address[4:0] == 5'h00 && writedata[0]) begin
          pending <= 1'b1;
        end
      end

      if (rd_req) readdata <= rd_mux;

      disp_x     <= active[disp_idx][7:0];
      disp_y     <= active[disp_idx][15:8];
      disp_pat   <= active[disp_idx][23:16];
      disp_flags <= active[disp_idx][31:24];
    end
  end

endmodule
